// File: rtl/rsa_cpu_pkg.sv
// Shared types for the instruction fetch queue: FSM states, queue entry payload and defaults.
package rsa_cpu_pkg;

  localparam int unsigned IFQ_DEPTH_DEF     = 4;
  localparam int unsigned IFQ_MAX_OUTST_DEF = 2;
  localparam int unsigned IFQ_AW            = 32;
  localparam int unsigned IFQ_DW            = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } ifq_state_e;

  typedef struct packed {
    logic [IFQ_AW-1:0] pc;
    logic [IFQ_DW-1:0] instr;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// In-order circular buffer of {pc,instr} entries with synchronous clear; clear wins over push/pop.
module ifq_fifo
  import rsa_cpu_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEPTH_DEF,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  ifq_entry_t    data_i,
  input  logic          pop_i,
  input  logic          clear_i,
  output ifq_entry_t    head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  ifq_entry_t    mem_q [DEPTH];
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];

  // A full queue may still accept a push in the same cycle it pops.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front end: issues imem reads from PCNext, queues returned words with their PC, flushes on redirect.
// Optional IFQ_PERF_CNT_EN adds perf_fetched / perf_flushed event counters.
module instr_fetch_queue
  import rsa_cpu_pkg::*;
#(
  parameter int unsigned DEPTH     = IFQ_DEPTH_DEF,
  parameter int unsigned MAX_OUTST = IFQ_MAX_OUTST_DEF,
  parameter int unsigned AW        = IFQ_AW,
  parameter int unsigned DW        = IFQ_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] PCNext,
  input  logic          PCSrc,
  output logic          pc_advance,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_rvalid,
  input  logic [DW-1:0] imem_rdata,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [DW-1:0] InstrD,
  output logic [AW-1:0] PCD
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0]   perf_fetched,
  output logic [31:0]   perf_flushed
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  ifq_state_e    state_q, state_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [AW-1:0] shadow_q [MAX_OUTST];
  logic [SW-1:0] sh_wr_q, sh_rd_q;

  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  ifq_entry_t    head, push_entry;
  logic          rsp, rsp_drop, rsp_keep, pop, push;

  function automatic logic [SW-1:0] sh_inc(input logic [SW-1:0] p);
    if (p == SW'(MAX_OUTST - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Credit check keeps count+outst within DEPTH so every kept response has a slot.
  assign imem_req   = (state_q != IDLE) && !PCSrc && (outst_q < CW'(MAX_OUTST)) &&
                      ((CW+1)'(fifo_count) + (CW+1)'(outst_q) < (CW+1)'(DEPTH));
  assign imem_addr  = imem_req ? PCNext : '0;
  assign pc_advance = imem_req;

  // Responses with nothing outstanding belong to reads abandoned by reset.
  assign rsp      = imem_rvalid && (outst_q != '0);
  assign rsp_drop = rsp && (drop_q != '0);
  assign rsp_keep = rsp && (drop_q == '0);

  assign instr_valid = !fifo_empty && !PCSrc;
  assign pop         = instr_valid && instr_ready;
  assign push        = rsp_keep && !PCSrc && (!fifo_full || pop);
  assign InstrD      = fifo_empty ? '0 : head.instr;
  assign PCD         = fifo_empty ? '0 : head.pc;

  assign push_entry.pc    = shadow_q[sh_rd_q];
  assign push_entry.instr = imem_rdata;

  ifq_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .clear_i (PCSrc),
    .head_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (!start) state_d = IDLE;
               else if (PCSrc) state_d = FLUSH;
      FLUSH:   if (!start) state_d = IDLE;
               else if ((drop_q == '0) && !PCSrc) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // On redirect everything still in flight after this edge is stale.
  always_comb begin
    outst_d = outst_q + CW'(imem_req) - CW'(rsp);
    drop_d  = drop_q;
    if (PCSrc)         drop_d = outst_q - CW'(rsp);
    else if (rsp_drop) drop_d = drop_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      outst_q <= '0;
      drop_q  <= '0;
      sh_wr_q <= '0;
      sh_rd_q <= '0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      if (imem_req) sh_wr_q <= sh_inc(sh_wr_q);
      if (rsp)      sh_rd_q <= sh_inc(sh_rd_q);
    end
  end

  always_ff @(posedge clk) begin
    if (imem_req) shadow_q[sh_wr_q] <= PCNext;
  end

`ifdef IFQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (push) perf_fetched <= perf_fetched + 32'd1;
      if (PCSrc)         perf_flushed <= perf_flushed + 32'(fifo_count) + 32'(rsp);
      else if (rsp_drop) perf_flushed <= perf_flushed + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a variable-latency imem model and a PC-control model.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b1;
  logic [31:0] PCNext = '0;
  logic        PCSrc = 1'b0;
  logic        pc_advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] InstrD;
  logic [31:0] PCD;
`ifdef IFQ_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  int          errors = 0;
  int          checks = 0;
  int          lat = 1;
  int          br_seq = 0;
  int          br_done = 0;
  logic [31:0] br_tgt = '0;
  int          req_cnt = 0;
  int          tcyc = 0;
  logic [31:0] pend_a [$];
  int          pend_d [$];
  logic [31:0] got_pc [$];
  logic [31:0] got_in [$];
  int          got_cy [$];

  instr_fetch_queue #(.DEPTH(4), .MAX_OUTST(2), .AW(32), .DW(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .PCNext      (PCNext),
    .PCSrc       (PCSrc),
    .pc_advance  (pc_advance),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .InstrD      (InstrD),
    .PCD         (PCD)
`ifdef IFQ_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_flushed(perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fi(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  // Environment: samples pre-edge values at the edge, drives responses/PC 1 time unit later.
  always @(posedge clk) begin
    logic adv;
    logic rst_s;
    adv   = pc_advance;
    rst_s = reset;
    tcyc  = tcyc + 1;
    if (!reset) begin
      pend_a.delete(); pend_d.delete();
      got_pc.delete(); got_in.delete(); got_cy.delete();
      req_cnt = 0;
    end else begin
      if (instr_valid && instr_ready) begin
        got_pc.push_back(PCD); got_in.push_back(InstrD); got_cy.push_back(tcyc);
      end
      if (imem_req) begin
        pend_a.push_back(imem_addr); pend_d.push_back(tcyc + lat - 1);
        req_cnt = req_cnt + 1;
      end
    end
    #1;
    if (!rst_s) begin
      PCNext = '0; PCSrc = 1'b0;
    end else if (br_seq != br_done) begin
      PCNext = br_tgt; PCSrc = 1'b1; br_done = br_seq;
    end else begin
      PCSrc = 1'b0;
      if (adv) PCNext = PCNext + 32'd4;
    end
    if (pend_d.size() > 0 && pend_d[0] <= tcyc) begin
      imem_rvalid = 1'b1; imem_rdata = fi(pend_a[0]);
      void'(pend_a.pop_front()); void'(pend_d.pop_front());
    end else begin
      imem_rvalid = 1'b0; imem_rdata = '0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset(input logic s, input logic r, input int l);
    reset = 1'b0; start = s; instr_ready = r; lat = l;
    repeat (3) tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; instr_ready = 1'b1; lat = 1;
    repeat (3) tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", instr_valid); end
    checks++; if (InstrD !== 32'h0) begin errors++; $display("FAIL rst_instrd: got %h exp 0", InstrD); end
    checks++; if (PCD !== 32'h0) begin errors++; $display("FAIL rst_pcd: got %h exp 0", PCD); end
`ifdef IFQ_PERF_CNT_EN
    checks++; if (perf_fetched !== 32'h0) begin errors++; $display("FAIL rst_perf_fetched: got %0d exp 0", perf_fetched); end
`endif
    reset = 1'b1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b exp 0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h exp 0", imem_addr); end
    checks++; if (pc_advance !== 1'b1) begin errors++; $display("FAIL first_adv: got %b exp 1", pc_advance); end
  endtask

  task automatic test_back_to_back();
    apply_reset(1'b1, 1'b1, 1);
    repeat (12) tick();
    checks++; if (got_pc.size() < 8) begin errors++; $display("FAIL b2b_count: got %0d exp >=8", got_pc.size()); end
    for (int i = 0; i < 8 && i < got_pc.size(); i++) begin
      checks++;
      if (got_pc[i] !== 32'(4 * i)) begin errors++; $display("FAIL b2b_pc[%0d]: got %h exp %h", i, got_pc[i], 32'(4 * i)); end
      checks++;
      if (got_in[i] !== fi(32'(4 * i))) begin errors++; $display("FAIL b2b_instr[%0d]: got %h exp %h", i, got_in[i], fi(32'(4 * i))); end
      if (i > 0) begin
        checks++;
        if (got_cy[i] !== got_cy[i-1] + 1) begin errors++; $display("FAIL b2b_gap[%0d]: got %0d exp %0d", i, got_cy[i], got_cy[i-1] + 1); end
      end
    end
`ifdef IFQ_PERF_CNT_EN
    checks++; if (perf_fetched !== 32'd10) begin errors++; $display("FAIL b2b_perf_fetched: got %0d exp 10", perf_fetched); end
`endif
  endtask

  task automatic test_fill();
    apply_reset(1'b1, 1'b0, 1);
    repeat (8) tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fill_req_stop: got %b exp 0", imem_req); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL fill_valid: got %b exp 1", instr_valid); end
    checks++; if (PCD !== 32'h0) begin errors++; $display("FAIL fill_head: got %h exp 0", PCD); end
    checks++; if (req_cnt !== 4) begin errors++; $display("FAIL fill_reqs: got %0d exp 4", req_cnt); end
    instr_ready = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fill_resume: got %b exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL fill_resume_addr: got %h exp 10", imem_addr); end
    checks++; if (PCD !== 32'h4) begin errors++; $display("FAIL fill_head2: got %h exp 4", PCD); end
    repeat (8) tick();
    checks++; if (got_pc.size() < 5) begin errors++; $display("FAIL fill_drain_count: got %0d exp >=5", got_pc.size()); end
    for (int i = 0; i < 5 && i < got_pc.size(); i++) begin
      checks++;
      if (got_pc[i] !== 32'(4 * i)) begin errors++; $display("FAIL fill_drain[%0d]: got %h exp %h", i, got_pc[i], 32'(4 * i)); end
    end
  endtask

  // Brings up a 2-queued / 2-in-flight state and redirects to 0x40; ends in the first cycle after redirect.
  task automatic redirect_setup();
    apply_reset(1'b1, 1'b0, 1);
    tick(); tick(); tick();
    lat = 3;
    tick();
    checks++; if (imem_addr !== 32'hC || imem_req !== 1'b1) begin errors++; $display("FAIL pre_redir_req: got %b/%h exp 1/c", imem_req, imem_addr); end
    br_tgt = 32'h40; br_seq++;
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_no_issue: got %b exp 0", imem_req); end
    instr_ready = 1'b1;
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b exp 0", instr_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_credit: got %b exp 0", imem_req); end
  endtask

  task automatic test_redirect();
    redirect_setup();
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL redir_resume: got %b exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL redir_addr: got %h exp 40", imem_addr); end
    repeat (8) tick();
    checks++; if (got_pc.size() < 2) begin errors++; $display("FAIL redir_count: got %0d exp >=2", got_pc.size()); end
    if (got_pc.size() >= 2) begin
      checks++; if (got_pc[0] !== 32'h40) begin errors++; $display("FAIL redir_pc0: got %h exp 40", got_pc[0]); end
      checks++; if (got_in[0] !== fi(32'h40)) begin errors++; $display("FAIL redir_in0: got %h exp %h", got_in[0], fi(32'h40)); end
      checks++; if (got_pc[1] !== 32'h44) begin errors++; $display("FAIL redir_pc1: got %h exp 44", got_pc[1]); end
    end
`ifdef IFQ_PERF_CNT_EN
    checks++; if (perf_flushed !== 32'd4) begin errors++; $display("FAIL redir_perf_flushed: got %0d exp 4", perf_flushed); end
`endif
  endtask

  task automatic test_double_redirect();
    redirect_setup();
    br_tgt = 32'h80; br_seq++;
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir2_no_issue: got %b exp 0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL redir2_resume: got %b exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h80) begin errors++; $display("FAIL redir2_addr: got %h exp 80", imem_addr); end
    repeat (8) tick();
    checks++; if (got_pc.size() < 2) begin errors++; $display("FAIL redir2_count: got %0d exp >=2", got_pc.size()); end
    if (got_pc.size() >= 2) begin
      checks++; if (got_pc[0] !== 32'h80) begin errors++; $display("FAIL redir2_pc0: got %h exp 80", got_pc[0]); end
      checks++; if (got_pc[1] !== 32'h84) begin errors++; $display("FAIL redir2_pc1: got %h exp 84", got_pc[1]); end
    end
`ifdef IFQ_PERF_CNT_EN
    checks++; if (perf_flushed !== 32'd4) begin errors++; $display("FAIL redir2_perf_flushed: got %0d exp 4", perf_flushed); end
`endif
  endtask

  task automatic test_stop();
    apply_reset(1'b1, 1'b0, 1);
    tick(); tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL stop_req_before: got %b/%h exp 1/4", imem_req, imem_addr); end
    start = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stop_no_req: got %b exp 0", imem_req); end
    checks++; if (instr_valid !== 1'b1 || PCD !== 32'h0) begin errors++; $display("FAIL stop_head: got %b/%h exp 1/0", instr_valid, PCD); end
    tick();
    instr_ready = 1'b1;
    repeat (6) tick();
    checks++; if (req_cnt !== 2) begin errors++; $display("FAIL stop_reqs: got %0d exp 2", req_cnt); end
    checks++; if (got_pc.size() !== 2) begin errors++; $display("FAIL stop_drained: got %0d exp 2", got_pc.size()); end
    if (got_pc.size() == 2) begin
      checks++; if (got_pc[1] !== 32'h4) begin errors++; $display("FAIL stop_pc1: got %h exp 4", got_pc[1]); end
    end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stop_empty: got %b exp 0", instr_valid); end
`ifdef IFQ_PERF_CNT_EN
    checks++; if (perf_fetched !== 32'd2) begin errors++; $display("FAIL stop_perf_fetched: got %0d exp 2", perf_fetched); end
    checks++; if (perf_flushed !== 32'd0) begin errors++; $display("FAIL stop_perf_flushed: got %0d exp 0", perf_flushed); end
`endif
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_fill();
    test_redirect();
    test_double_redirect();
    test_stop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
